// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, latencies and FSM state type.
// The EX-stage decoder imports this package so both sides agree on codes and timing.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// Define MDU_MADD_EN to enable the MADD/MADDU multiply-accumulate ops.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e  state_r, state_next_s;
  logic [3:0]  cnt_r;
  logic        busy_r;
  logic [31:0] hi_r, lo_r;
  logic [31:0] hi_tmp_r, lo_tmp_r;
  logic        div_zero_r;

  logic        is_mul_s, is_div_s, is_signed_s;
`ifdef MDU_MADD_EN
  logic        is_acc_s;
`endif
  logic [63:0] a_ext_s, b_ext_s, prod_s, mul_res_s, tmp_next_s;
  logic [31:0] quot_s, rem_s;
  logic        b_zero_s;
  logic        launch_s, commit_s, mthi_s, mtlo_s;

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

  // Decode the op code into operation class flags
  always_comb begin
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
`ifdef MDU_MADD_EN
    is_acc_s    = 1'b0;
`endif
    case (mdu_op)
      OP_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
      OP_MULTU: is_mul_s = 1'b1;
      OP_DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
      OP_DIVU:  is_div_s = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; is_acc_s = 1'b1; end
      OP_MADDU: begin is_mul_s = 1'b1; is_acc_s = 1'b1; end
`endif
      default:  is_mul_s = 1'b0;
    endcase
  end

  // Compute the full result from the live operands; it is latched at the start edge
  always_comb begin
    a_ext_s  = is_signed_s ? {{32{A[31]}}, A} : {32'd0, A};
    b_ext_s  = is_signed_s ? {{32{B[31]}}, B} : {32'd0, B};
    // Low 64 bits of the extended product are correct for both signednesses
    prod_s   = a_ext_s * b_ext_s;
`ifdef MDU_MADD_EN
    mul_res_s = is_acc_s ? (prod_s + {hi_r, lo_r}) : prod_s;
`else
    mul_res_s = prod_s;
`endif
    b_zero_s = (B == 32'd0);
    if (b_zero_s) begin
      quot_s = 32'd0;
      rem_s  = 32'd0;
    end else if (is_signed_s) begin
      quot_s = $signed(A) / $signed(B);
      rem_s  = $signed(A) % $signed(B);
    end else begin
      quot_s = A / B;
      rem_s  = A % B;
    end
    tmp_next_s = is_div_s ? {rem_s, quot_s} : mul_res_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (is_mul_s || is_div_s)) state_next_s = ST_RUN;
        else                                 state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == 4'd1) state_next_s = ST_IDLE;
        else               state_next_s = ST_RUN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Per-state control strobes; starts during RUN are deliberately ignored
  always_comb begin
    launch_s = 1'b0;
    commit_s = 1'b0;
    mthi_s   = 1'b0;
    mtlo_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        launch_s = start && (is_mul_s || is_div_s);
        mthi_s   = start && (mdu_op == OP_MTHI);
        mtlo_s   = start && (mdu_op == OP_MTLO);
      end
      ST_RUN:  commit_s = (cnt_r == 4'd1) && !div_zero_r;
      default: commit_s = 1'b0;
    endcase
  end

  // State, counter, staging and architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      busy_r     <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      hi_tmp_r   <= 32'd0;
      lo_tmp_r   <= 32'd0;
      div_zero_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      if (launch_s) begin
        cnt_r      <= is_div_s ? DIV_CYCLES : MUL_CYCLES;
        hi_tmp_r   <= tmp_next_s[63:32];
        lo_tmp_r   <= tmp_next_s[31:0];
        div_zero_r <= is_div_s && b_zero_s;
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (commit_s)    hi_r <= hi_tmp_r;
      else if (mthi_s) hi_r <= A;
      if (commit_s)    lo_r <= lo_tmp_r;
      else if (mtlo_s) lo_r <= A;
    end
  end

endmodule
